// File: rtl/ins_seq_ctrl_pkg.sv
// Shared definitions for the fetch/decode/execute sequencer:
// state encodings, default field widths and the HALT opcode.
package ins_seq_ctrl_pkg;

    // Encodings are visible on the debug state port, so keep them fixed.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4,
        ST_STEP   = 3'd5
    } state_t;

    localparam int                  DEF_ADDR_W   = 8;
    localparam int                  DEF_INS_W    = 16;
    localparam int                  DEF_OPC_W    = 5;
    // The opcode occupies the top OPC_W bits of the IR.
    localparam logic [DEF_OPC_W-1:0] DEF_HALT_OPC = 5'b00001;

endpackage

// File: rtl/ins_seq_ctrl_if.sv
// Sequencer-side bus: instruction-memory fetch handshake, IR load/readback
// and the execute-stage enable/done handshake with branch resolution.
interface ins_seq_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int INS_W  = 16
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic              ir_en;
    logic [INS_W-1:0]  ir_q;
    logic              exec_en;
    logic              exec_done;
    logic              jmp_taken;
    logic [ADDR_W-1:0] jmp_addr;

    // Sequencer side.
    modport master (
        output mem_req, mem_addr, ir_en, exec_en,
        input  mem_ack, ir_q, exec_done, jmp_taken, jmp_addr
    );

    // Memory / IR / execute datapath side.
    modport slave (
        input  mem_req, mem_addr, ir_en, exec_en,
        output mem_ack, ir_q, exec_done, jmp_taken, jmp_addr
    );
endinterface

// File: rtl/ins_seq_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer. Owns the PC, requests
// instructions, pulses the IR load enable on the accepted fetch, stops on
// HALT and hands each instruction to the execute stage.
// Optional feature macro: SINGLE_STEP_EN -- adds a step input; after every
// executed instruction the sequencer parks in STEP until step is high.
module ins_seq_ctrl
    import ins_seq_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                INS_W    = DEF_INS_W,
    parameter int                OPC_W    = DEF_OPC_W,
    parameter logic [OPC_W-1:0]  HALT_OPC = DEF_HALT_OPC,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
`ifdef SINGLE_STEP_EN
    input  logic              step,
`endif
    ins_seq_ctrl_if.master    bus,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic [2:0]        state
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              mem_req_q;
    logic              exec_en_q;
    logic              halted_q;
    logic [OPC_W-1:0]  opcode;

    assign opcode = bus.ir_q[INS_W-1 -: OPC_W];

    // Next state and next PC; the PC only moves on start, accepted fetch
    // or a taken branch reported with exec_done.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    pc_d    = RESET_PC;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (bus.mem_ack) begin
                    pc_d    = pc_q + 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = (opcode == HALT_OPC) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                if (bus.exec_done) begin
                    if (bus.jmp_taken) pc_d = bus.jmp_addr;
`ifdef SINGLE_STEP_EN
                    state_d = ST_STEP;
`else
                    state_d = ST_FETCH;
`endif
                end
            end
`ifdef SINGLE_STEP_EN
            ST_STEP: begin
                if (step) state_d = ST_FETCH;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // State, PC and the registered strobes; strobes are decoded from the
    // next state so they line up with the state they belong to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            mem_req_q <= 1'b0;
            exec_en_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            mem_req_q <= (state_d == ST_FETCH);
            exec_en_q <= (state_d == ST_EXEC);
            halted_q  <= (state_d == ST_HALT);
        end
    end

    // IR load is combinational so the IR captures the instruction on the
    // same edge the fetch is accepted.
    assign bus.ir_en    = (state_q == ST_FETCH) && bus.mem_ack;
    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = pc_q;
    assign bus.exec_en  = exec_en_q;
    assign pc           = pc_q;
    assign halted       = halted_q;
    assign state        = state_q;

endmodule
